multiword_add_sequencer: RTL
============================

MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 SHALL have parameter NUM_SLICES, default 4, number of 16-bit slices per operand (operand width W = 16*NUM_SLICES, 64 by default).
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, operand pair offered.
REQ-005 SHALL have port in_ready, output, 1, sequencer can accept operands.
REQ-006 SHALL have port a, input, W, first operand.
REQ-007 SHALL have port b, input, W, second operand.
REQ-008 SHALL have port c_in, input, 1, carry into slice 0.
REQ-009 SHALL have port sub, input, 1, subtract request (see Configuration).
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port out, output, W, sum.
REQ-013 SHALL have port c_out, output, 1, carry out of the top slice.

Function
REQ-014 SHALL compute {c_out,out} = a + b + c_in (mod 2^(W+1)) using one 16-bit carry-select adder, time-multiplexed one slice per cycle, least-significant slice first.
REQ-015 SHALL implement states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 IDLE: on in_valid, register a, b, c_in and sub, clear the slice counter, and go to BUSY; otherwise remain in IDLE.
REQ-017 BUSY: each cycle, add slice k of the registered operands with the carry register, write the 16-bit sum into slice k of the result register, load the slice carry-out into the carry register, and increment k.
REQ-018 BUSY -> DONE after slice NUM_SLICES-1 is processed; out_valid SHALL rise exactly NUM_SLICES cycles after the accepting edge.
REQ-019 DONE: out and c_out SHALL hold stable while out_valid=1 and out_ready=0; on out_ready, go to IDLE.
REQ-020 No new operands SHALL be accepted in the cycle a result is consumed; the minimum initiation interval is NUM_SLICES+2 cycles.
REQ-021 Operand inputs SHALL be ignored outside IDLE; in_valid held high across BUSY/DONE SHALL NOT start a second operation.
REQ-022 Carries SHALL propagate across all slices; all-ones + 1 SHALL wrap to zero with c_out=1.

Reset
REQ-023 rst SHALL force IDLE and clear the counter, carry, operand and result registers, so out=0, c_out=0, out_valid=0 and in_ready=1 in the cycle after reset.
REQ-024 rst asserted in BUSY or DONE SHALL abort the operation; the partial or pending result SHALL be discarded and never presented.
REQ-025 rst SHALL take priority over all handshakes in the same cycle.

Configuration
REQ-026 With macro MWADD_SUB_EN defined, sub=1 at acceptance SHALL compute a - b, implemented as a + ~b with carry into slice 0 forced to 1 and c_in ignored; c_out=1 SHALL mean no borrow.
REQ-027 Without MWADD_SUB_EN, the sub port SHALL remain present, its value SHALL be ignored, and every operation SHALL be an add.

Structure
REQ-028 A shared package SHALL hold the slice width constant (16) and the state encoding for IDLE, BUSY and DONE.
REQ-029 The slice adder SHALL be one instance of the existing carry_select_adder module (16-bit a, b, c_in; out, c_out); no other sub-modules.

Verification
REQ-030 Reset then add a=1, b=10, c_in=0 -> out=11, c_out=0; out_valid rises 4 cycles after acceptance.
REQ-031 a=64'h0000_0000_0000_FFFF, b=1 -> out=64'h0000_0000_0001_0000, c_out=0 (carry crosses a slice boundary).
REQ-032 a=64'hFFFF_FFFF_FFFF_FFFF, b=0, c_in=1 -> out=0, c_out=1.
REQ-033 Result 15+31=46 with out_ready held low for 3 cycles -> out=46 stable, in_ready=0 throughout; consumed on the first out_ready cycle; in_ready=1 on the next cycle.
REQ-034 rst pulsed in the second BUSY cycle of 128+1478 -> out_valid never asserts for it; the next operation, 94+333, returns 427.
REQ-035 With MWADD_SUB_EN defined, 5-7 -> out=64'hFFFF_FFFF_FFFF_FFFE, c_out=0; without it, the same stimulus with sub=1 -> out=12.

Source files
------------

// File: rtl/multiword_add_sequencer_pkg.sv
// Shared constants and state encoding for the multiword add sequencer.
// The slice adder width and the IDLE/BUSY/DONE encoding are defined here.
package multiword_add_sequencer_pkg;

    localparam int SLICE_W = 16;
    localparam int HALF_W  = SLICE_W / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiword_add_sequencer_csa.sv
// 16-bit carry-select adder: the low byte ripples while the high byte is
// precomputed for both carry values and selected by the low-byte carry.
import multiword_add_sequencer_pkg::*;

module carry_select_adder (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c_in,
    output logic [SLICE_W-1:0] out,
    output logic               c_out
);

    logic [HALF_W:0] lo_sum;
    logic [HALF_W:0] hi_sum0;
    logic [HALF_W:0] hi_sum1;

    assign lo_sum  = {1'b0, a[HALF_W-1:0]} + {1'b0, b[HALF_W-1:0]} + {{HALF_W{1'b0}}, c_in};
    assign hi_sum0 = {1'b0, a[SLICE_W-1:HALF_W]} + {1'b0, b[SLICE_W-1:HALF_W]};
    assign hi_sum1 = {1'b0, a[SLICE_W-1:HALF_W]} + {1'b0, b[SLICE_W-1:HALF_W]} + {{HALF_W{1'b0}}, 1'b1};

    assign {c_out, out} = lo_sum[HALF_W] ? {hi_sum1, lo_sum[HALF_W-1:0]}
                                         : {hi_sum0, lo_sum[HALF_W-1:0]};

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide adder that reuses one 16-bit slice adder, one slice per cycle, LSB first.
// Define MWADD_SUB_EN to honour the sub input (a - b as a + ~b + 1).
import multiword_add_sequencer_pkg::*;

module multiword_add_sequencer #(
    parameter int NUM_SLICES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] a,
    input  logic [SLICE_W*NUM_SLICES-1:0] b,
    input  logic                        c_in,
    input  logic                        sub,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] out,
    output logic                        c_out
);

    localparam int W     = SLICE_W * NUM_SLICES;
    localparam int CNT_W = $clog2(NUM_SLICES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SLICES - 1);

    state_t state;
    state_t next_state;

    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [W-1:0]       result;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        slice_base;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)     next_state = BUSY;
            BUSY:    if (cnt == LAST)  next_state = DONE;
            DONE:    if (out_ready)    next_state = IDLE;
            default:                   next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    assign slice_base = 32'(cnt) * 32'(SLICE_W);
    assign slice_a    = a_reg[slice_base +: SLICE_W];
    assign slice_b    = b_reg[slice_base +: SLICE_W];

    carry_select_adder u_slice_adder (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry),
        .out   (slice_sum),
        .c_out (slice_carry)
    );

`ifndef MWADD_SUB_EN
    logic unused_sub;
    assign unused_sub = sub;
`endif

    // Subtraction is folded in at capture time so BUSY only ever adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        cnt   <= '0;
`ifdef MWADD_SUB_EN
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : c_in;
`else
                        b_reg <= b;
                        carry <= c_in;
`endif
                    end
                end
                BUSY: begin
                    result[slice_base +: SLICE_W] <= slice_sum;
                    carry <= slice_carry;
                    cnt   <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign out   = result;
    assign c_out = carry;

endmodule
